// File: rtl/bram_arb.sv
// bram_arb: write-priority arbiter sharing one single-port BRAM between a capture writer and a display reader.
// Optional `define BRAM_ARB_STATS_EN adds a saturating read-stall counter output (o_rd_stall_cnt).
module bram_arb #(
  parameter int BRAM_DEPTH = 16384,
  parameter int DATA_WIDTH = 12,
  parameter int BURST_MAX  = 16,
  localparam int AW = $clog2(BRAM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_valid,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  input  logic                  i_rd_valid,
  input  logic [AW-1:0]         i_rd_addr,
  output logic                  o_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_data_valid,
  output logic                  o_bram_en,
  output logic                  o_bram_we,
  output logic [AW-1:0]         o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_wdata,
  input  logic [DATA_WIDTH-1:0] i_bram_rdata
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [15:0]           o_rd_stall_cnt
`endif
);

  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t     state_q, state_d;
  logic [7:0] burst_q, burst_d;
  logic       wr_grant, rd_grant;
  logic       rd_vld_q;

  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    state_d  = IDLE;
    burst_d  = burst_q;
    if (!i_rst) begin
      // A waiting read wins only once the write burst has reached its limit.
      wr_grant = i_wr_valid && !(i_rd_valid && (burst_q == BURST_LIM));
      rd_grant = i_rd_valid && !wr_grant;
    end
    if (wr_grant)      state_d = WR;
    else if (rd_grant) state_d = RD;
    if (!i_rd_valid || rd_grant) burst_d = 8'd0;
    else if (wr_grant)           burst_d = burst_q + 8'd1;
  end

  assign o_wr_ready = wr_grant;
  assign o_rd_ready = rd_grant;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      burst_q      <= 8'd0;
      o_bram_en    <= 1'b0;
      o_bram_we    <= 1'b0;
      o_bram_addr  <= '0;
      o_bram_wdata <= '0;
      rd_vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      o_bram_en <= wr_grant || rd_grant;
      o_bram_we <= wr_grant;
      if (wr_grant) begin
        o_bram_addr  <= i_wr_addr;
        o_bram_wdata <= i_wr_data;
      end else if (rd_grant) begin
        o_bram_addr  <= i_rd_addr;
      end
      // The BRAM owns a read this cycle, so its data arrives next cycle.
      rd_vld_q <= (state_q == RD);
    end
  end

  assign o_rd_data_valid = rd_vld_q;
  assign o_rd_data       = rd_vld_q ? i_bram_rdata : '0;

`ifdef BRAM_ARB_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      o_rd_stall_cnt <= 16'd0;
    else if (i_rd_valid && !rd_grant && (o_rd_stall_cnt != 16'hFFFF))
      o_rd_stall_cnt <= o_rd_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bram_arb.sv
// Bench for bram_arb: randomized and directed traffic against a grant-order reference model and a BRAM model.
module tb_bram_arb;
  localparam int DEPTH = 16384;
  localparam int DW    = 12;
  localparam int BMAX  = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0, rd_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_ready, rd_data_valid, bram_en, bram_we;
  logic [DW-1:0] rd_data, bram_wdata, bram_rdata;
  logic [AW-1:0] bram_addr;
`ifdef BRAM_ARB_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  bram_arb #(.BRAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .BURST_MAX(BMAX)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .o_rd_ready(rd_ready),
    .o_rd_data(rd_data), .o_rd_data_valid(rd_data_valid),
    .o_bram_en(bram_en), .o_bram_we(bram_we), .o_bram_addr(bram_addr),
    .o_bram_wdata(bram_wdata), .i_bram_rdata(bram_rdata)
`ifdef BRAM_ARB_STATS_EN
    , .o_rd_stall_cnt(stall_cnt)
`endif
  );

  // Single-port BRAM with one cycle of read latency.
  logic [DW-1:0] bram [DEPTH];
  initial begin
    bram_rdata = '0;
    for (int i = 0; i < DEPTH; i++) bram[i] = DW'(i * 37 + 5);
    forever begin
      @(posedge clk);
      if (bram_en) begin
        if (bram_we) bram[bram_addr] <= bram_wdata;
        bram_rdata <= bram[bram_addr];
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory contents follow grant order; pipeline slots hold what the outputs should show.
  logic [DW-1:0] ref_mem [DEPTH];
  int            streak = 0, stall_ref = 0;
  bit            e_en = 0, e_we = 0, e_rv = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rd = '0, s_rd = '0;
  int            n_wr = 0, n_rd = 0, n_rv = 0;

  task automatic step();
    bit xw, xr;
    @(negedge clk);
    xw = wr_valid && !(rd_valid && streak == BMAX);
    xr = rd_valid && !xw;
    check("wr_ready", wr_ready, xw);
    check("rd_ready", rd_ready, xr);
    check("bram_en", bram_en, e_en);
    check("bram_we", bram_we, e_we);
    if (e_en) check("bram_addr", bram_addr, e_addr);
    if (e_en && e_we) check("bram_wdata", bram_wdata, e_wdata);
    check("rd_data_valid", rd_data_valid, e_rv);
    if (e_rv) check("rd_data", rd_data, e_rd);
`ifdef BRAM_ARB_STATS_EN
    check("stall_cnt", stall_cnt, stall_ref);
`endif
    if (wr_ready) n_wr++;
    if (rd_ready) n_rd++;
    if (rd_data_valid) n_rv++;
    e_rv = e_en && !e_we;
    e_rd = s_rd;
    e_en = xw || xr;
    e_we = xw;
    e_addr = xw ? wr_addr : rd_addr;
    e_wdata = wr_data;
    if (xw) ref_mem[wr_addr] = wr_data;
    if (xr) s_rd = ref_mem[rd_addr];
    if (rd_valid && !xr) stall_ref++;
    if (!rd_valid || xr) streak = 0;
    else if (xw) streak++;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    streak = 0; stall_ref = 0;
    e_en = 0; e_we = 0; e_rv = 0;
  endtask

  initial begin
    int w0, r0, v0, rate;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i * 37 + 5);

    // Reset state, with requests present.
    wr_valid = 1'b1; rd_valid = 1'b1;
    #12;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_rd_valid", rd_data_valid, 0);
    wr_valid = 1'b0; rd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Single write right after reset release, then read it back.
    wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 12'hABC;
    step();
    wr_valid = 1'b0;
    check("w_bram_en", bram_en, 1);
    check("w_bram_we", bram_we, 1);
    check("w_bram_addr", bram_addr, 5);
    check("w_bram_wdata", bram_wdata, 12'hABC);
    rd_valid = 1'b1; rd_addr = AW'(5);
    step();
    rd_valid = 1'b0;
    step();
    check("r_valid", rd_data_valid, 1);
    check("r_data", rd_data, 12'hABC);
    step();

    // Back-to-back reads 0..7.
    v0 = n_rv;
    for (int a = 0; a < 8; a++) begin
      rd_valid = 1'b1; rd_addr = AW'(a);
      step();
    end
    rd_valid = 1'b0;
    repeat (3) step();
    check("burst_read_count", n_rv - v0, 8);

    // Randomized traffic with varying request density.
    for (int blk = 0; blk < 10; blk++) begin
      rate = $urandom_range(0, 3);
      repeat (150) begin
        wr_valid = ($urandom_range(0, 3) <= rate);
        rd_valid = ($urandom_range(0, 3) <= rate);
        wr_addr  = AW'($urandom_range(0, 31));
        rd_addr  = AW'($urandom_range(0, 31));
        wr_data  = DW'($urandom);
        step();
      end
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (3) step();

    // Reset one cycle after a read is accepted: in-flight read must vanish.
    rd_valid = 1'b1; rd_addr = AW'(3);
    step();
    rd_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_bram_en", bram_en, 0);
    check("arst_bram_we", bram_we, 0);
    check("arst_bram_addr", bram_addr, 0);
    check("arst_bram_wdata", bram_wdata, 0);
    check("arst_rd_valid", rd_data_valid, 0);
    check("arst_rd_data", rd_data, 0);
    wr_valid = 1'b1; rd_valid = 1'b1;
    #1;
    check("arst_wr_ready", wr_ready, 0);
    check("arst_rd_ready", rd_ready, 0);
    wr_valid = 1'b0; rd_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    v0 = n_rv;
    repeat (4) step();
    check("no_valid_after_rst", n_rv - v0, 0);

    // Both requesters continuously active: 16 writes then 1 read, repeating.
    w0 = n_wr; r0 = n_rd;
    wr_valid = 1'b1; rd_valid = 1'b1;
    for (int c = 0; c < 51; c++) begin
      wr_addr = AW'($urandom_range(0, 31));
      rd_addr = AW'($urandom_range(0, 31));
      wr_data = DW'($urandom);
      step();
`ifdef BRAM_ARB_STATS_EN
      if (c == 39) check("stall_after_40", stall_cnt, 38);
`endif
    end
    check("contend_writes", n_wr - w0, 48);
    check("contend_reads", n_rd - r0, 3);
    wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
